uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//   Memory-mapped UART transmitter; a bus responder on the CPU bus (bus_data/bus_addr/mem_read/mem_write),
//   alongside data_memory. CPU writes bytes into a TX FIFO; block serialises them as 8N1, LSB first.
//   Occupies a 4-word window directly above data memory (0x00000-0x007FF); gives software a debug/console output.
// PARAMETERS
//   ADDR_WIDTH   20        bus address width
//   DATA_WIDTH   16        bus data width
//   BASE_ADDR    20'h00800 first word of register window (4 words: BASE..BASE+3)
//   FIFO_DEPTH   8         TX FIFO entries; power of 2, >=2
//   DEFAULT_DIV  434       reset value of baud divisor (clk cycles per bit)
// PORTS
//   clk       in     1           system clock (PLL output)
//   reset     in     1           synchronous, active-high
//   bus_data  inout  DATA_WIDTH  shared data bus; driven only during a hit read, else 'z
//   bus_addr  in     ADDR_WIDTH  word address
//   read      in     1           bus read strobe (CPU mem_read)
//   write     in     1           bus write strobe (CPU mem_write)
//   tx        out    1           serial output, idle high
//   irq       out    1           level: FIFO empty and no frame in progress
// BEHAVIOUR
//   Decode: hit = bus_addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]; off = bus_addr[1:0].
//   Registers: off0 TXDATA (W: push bus_data[7:0]; R: 0); off1 STATUS (R); off2 DIV (R/W, 16b); off3 reserved (R 0, W ignored).
//   STATUS: [0] full, [1] empty, [2] busy (FSM != IDLE), [3] overflow (sticky), [7:4] FIFO count (saturates at 15), others 0.
//   Read: combinational; bus_data = reg when read && hit && !write, else 'z. Reads have no side effects.
//   Write: sampled on rising clk when write && hit. read && write in same cycle: write wins, bus not driven.
//   TXDATA write when full: data dropped, overflow <= 1. Writing STATUS with bit3=1 clears overflow.
//   Push and pop in same cycle: both take effect, count unchanged. Push to full FIFO is dropped
//     even if a pop occurs in that cycle.
//   DIV write: value 0 stored as 1. Divisor is latched at frame start; mid-frame writes apply to next frame.
//   TX FSM: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE, or STOP -> START if FIFO non-empty (back-to-back, no idle gap).
//     IDLE: on FIFO non-empty, pop head into shift reg, latch div, enter START; tx=0 from the next cycle.
//     Each state/bit lasts exactly div cycles (bit counter 0..div-1); DATA shifts LSB first; STOP tx=1.
//     Frame length = 10*div cycles. Latency: TXDATA write at edge N -> tx falls at edge N+2 when idle.
//   Reset (any time, incl. mid-frame): tx=1, FSM IDLE, FIFO empty, overflow=0, DIV=DEFAULT_DIV, irq=1,
//     bus_data='z. A partial frame is abandoned; no glitch below idle level after reset.
//   irq = empty && FSM==IDLE; goes low the cycle after the first push.
// STRUCTURE
//   Shared include uart_defs.vh: register offsets, STATUS bit positions, FSM state encodings.
//   Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/count; pointer wrap uses an
//     extra MSB to tell full from empty.
//   Top: address decode + tri-state driver, register file, TX FSM with baud and bit counters.
// TESTING
//   1 Reset, DIV=4, write 0xA5 to BASE -> tx: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 cycles; irq returns 1.
//   2 Write 9 bytes back-to-back (DEPTH=8, idle FSM) -> first pops, 8 stay queued, none dropped;
//     10th write while full -> STATUS[3]=1, count=8; write STATUS 0x0008 -> bit3=0.
//   3 Read BASE+1 after reset -> 0x0002; read 0x007FF and 0x00804 -> bus_data stays 'z; read+write same cycle -> 'z.
//   4 Queue 3 bytes, DIV=2 -> exactly 60 cycles from first start bit to final stop end, with no idle gap between frames.
//   5 DIV write 8 mid-frame with DIV=4 -> current frame stays at 4 cycles/bit, next frame uses 8; write DIV=0 -> reads back 1.
//   6 Assert reset during DATA bit 3 -> next cycle tx=1, STATUS=0x0002, DIV=DEFAULT_DIV; a new write transmits a clean frame.

Source files
------------

// File: rtl/uart_tx_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               register offsets, STATUS bit positions, TX FSM states and a
//               small saturating helper for the STATUS count field.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_periph_pkg;

    // Register offsets inside the 4-word window
    localparam logic [1:0] c_off_txdata = 2'd0;
    localparam logic [1:0] c_off_status = 2'd1;
    localparam logic [1:0] c_off_div    = 2'd2;
    localparam logic [1:0] c_off_rsvd   = 2'd3;

    // STATUS bit positions
    localparam int c_st_full  = 0;
    localparam int c_st_empty = 1;
    localparam int c_st_busy  = 2;
    localparam int c_st_ovf   = 3;
    localparam int c_st_cnt_lo = 4;
    localparam int c_st_cnt_hi = 7;

    // Transmit state machine encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // FIFO occupancy squeezed into the 4-bit STATUS field, clamped at 15
    function automatic logic [3:0] sat_count4(input logic [31:0] n);
        if (n > 32'd15) begin
            return 4'hF;
        end
        return n[3:0];
    endfunction

endpackage : uart_tx_periph_pkg
`default_nettype wire

// File: rtl/uart_tx_periph_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph_if
// Description : CPU bus control signals (word address plus read/write
//               strobes). The shared tri-state data bus stays a plain inout
//               port on the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_periph_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  read;
    logic                  write;

    // CPU side drives the strobes and address
    modport master (
        output bus_addr,
        output read,
        output write
    );

    // Peripheral side only observes them
    modport slave (
        input bus_addr,
        input read,
        input write
    );
endinterface : uart_tx_periph_if
`default_nettype wire

// File: rtl/uart_tx_periph_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph_sync_fifo
// Description : Single-clock FIFO. Pointers carry one extra MSB so that
//               equal low bits with differing MSBs means full. A push into a
//               full FIFO is dropped even when a pop happens the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_periph_sync_fifo
    import uart_tx_periph_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire                       clk,
    input  wire                       reset,
    input  wire                       i_push,
    input  wire  [WIDTH-1:0]          i_wdata,
    input  wire                       i_pop,
    output logic [WIDTH-1:0]          o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_count   = r_wptr - r_rptr;
    assign o_rdata   = r_mem[r_rptr[c_aw-1:0]];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer update; push and pop may both land in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage write, no reset needed since reads are gated by the pointers
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
        end
    end

endmodule : uart_tx_periph_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph
// Description : Memory-mapped 8N1 UART transmitter on the CPU bus. Four-word
//               register window (TXDATA, STATUS, DIV, reserved), TX FIFO,
//               and a frame FSM with a per-bit baud counter. tx is registered
//               so it trails the FSM state by one clock and never glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 20,
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 20'h00800,
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    DEFAULT_DIV = 434
) (
    input  wire                   clk,
    input  wire                   reset,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    uart_tx_periph_if.slave       bus,
    output logic                  tx,
    output logic                  irq
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic                  w_hit;
    logic [1:0]            w_off;
    logic                  w_wr;
    logic                  w_drive;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_status;
    logic [15:0]           w_wdata16;

    // Register file
    logic [15:0]           r_div;
    logic                  r_ovf;

    // FIFO connections
    logic                  w_push;
    logic                  w_pop;
    logic [7:0]            w_fifo_rdata;
    logic                  w_full;
    logic                  w_empty;
    logic [c_cnt_w-1:0]    w_count;

    // Transmit FSM
    tx_state_t             r_state;
    tx_state_t             w_state_nx;
    logic [15:0]           r_baud_cnt;
    logic [15:0]           w_cnt_nx;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_nx;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_nx;
    logic [15:0]           r_cur_div;
    logic [15:0]           w_div_nx;
    logic                  r_tx;
    logic                  w_tx_nx;
    logic                  w_bit_end;

    assign w_hit     = (bus.bus_addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
    assign w_off     = bus.bus_addr[1:0];
    assign w_wr      = bus.write && w_hit;
    assign w_drive   = bus.read && w_hit && !bus.write;
    assign w_wdata16 = bus_data[15:0];
    assign w_push    = w_wr && (w_off == c_off_txdata);

    // Only drive the shared bus for a read hit that is not also a write
    assign bus_data = w_drive ? w_rdata : {DATA_WIDTH{1'bz}};

    // STATUS word assembly
    always_comb begin
        w_status                          = '0;
        w_status[c_st_full]               = w_full;
        w_status[c_st_empty]              = w_empty;
        w_status[c_st_busy]               = (r_state != S_IDLE);
        w_status[c_st_ovf]                = r_ovf;
        w_status[c_st_cnt_hi:c_st_cnt_lo] = sat_count4(32'(w_count));
    end

    // Read mux; TXDATA and reserved read as zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_off_status: w_rdata = w_status;
            c_off_div:    w_rdata = DATA_WIDTH'(r_div);
            default:      w_rdata = '0;
        endcase
    end

    // DIV and sticky overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= 16'(DEFAULT_DIV);
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (w_off == c_off_div)) begin
                r_div <= (w_wdata16 == 16'd0) ? 16'd1 : w_wdata16;
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == c_off_status) && w_wdata16[c_st_ovf]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    uart_tx_periph_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata16[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_bit_end = (r_baud_cnt == (r_cur_div - 16'd1));

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_cur_div  <= 16'd1;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_cnt_nx;
            r_bit_idx  <= w_bit_nx;
            r_shift    <= w_shift_nx;
            r_cur_div  <= w_div_nx;
            r_tx       <= w_tx_nx;
        end
    end

    // FSM next state, FIFO pop and the line level for the next cycle
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_baud_cnt;
        w_bit_nx   = r_bit_idx;
        w_shift_nx = r_shift;
        w_div_nx   = r_cur_div;
        w_pop      = 1'b0;
        w_tx_nx    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_fifo_rdata;
                    w_div_nx   = r_div;
                    w_cnt_nx   = 16'd0;
                    w_bit_nx   = 3'd0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_tx_nx = 1'b0;
                if (w_bit_end) begin
                    w_cnt_nx   = 16'd0;
                    w_bit_nx   = 3'd0;
                    w_state_nx = S_DATA;
                end else begin
                    w_cnt_nx = r_baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                w_tx_nx = r_shift[0];
                if (w_bit_end) begin
                    w_cnt_nx   = 16'd0;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_bit_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                w_tx_nx = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nx = 16'd0;
                    // Chain straight into the next frame when data is waiting
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_fifo_rdata;
                        w_div_nx   = r_div;
                        w_bit_nx   = 3'd0;
                        w_state_nx = S_START;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_baud_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign tx  = r_tx;
    assign irq = w_empty && (r_state == S_IDLE);

endmodule : uart_tx_periph
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_periph
// Description : Directed self-checking bench for uart_tx_periph. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

    localparam logic [19:0] BASE   = 20'h00800;
    localparam logic [19:0] A_TX   = BASE;
    localparam logic [19:0] A_STAT = BASE + 20'd1;
    localparam logic [19:0] A_DIV  = BASE + 20'd2;
    localparam logic [19:0] A_RSVD = BASE + 20'd3;

    logic        clk;
    logic        reset;
    wire  [15:0] bus_data;
    logic        drv_en;
    logic [15:0] drv_val;
    logic        tx;
    logic        irq;

    int          n_checks;
    int          n_err;
    logic [15:0] v;
    logic [19:0] ba [8];
    logic [15:0] bd [8];
    logic        done;

    uart_tx_periph_if #(.ADDR_WIDTH(20)) bus_if ();

    assign bus_data = drv_en ? drv_val : 16'hzzzz;

    uart_tx_periph #(
        .ADDR_WIDTH  (20),
        .DATA_WIDTH  (16),
        .BASE_ADDR   (20'h00800),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (434)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_data (bus_data),
        .bus      (bus_if),
        .tx       (tx),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // An undriven bus reads as z in a 4-state simulator and 0 in a 2-state one
    task automatic chk_undriven(input string tag, input logic [15:0] obs);
        n_checks++;
        assert ((obs === 16'hzzzz) || (obs === 16'h0000)) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected undriven (z)", tag, obs);
        end
    endtask

    task automatic bus_read(input logic [19:0] addr, output logic [15:0] data);
        bus_if.bus_addr = addr;
        bus_if.read     = 1'b1;
        #1;
        data            = bus_data;
        bus_if.read     = 1'b0;
    endtask

    task automatic bus_write(input logic [19:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus_if.bus_addr = addr;
        bus_if.write    = 1'b1;
        drv_en          = 1'b1;
        drv_val         = data;
        @(negedge clk);
        bus_if.write    = 1'b0;
        drv_en          = 1'b0;
    endtask

    // Writes ba/bd entries on consecutive clock edges
    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.bus_addr = ba[i];
            bus_if.write    = 1'b1;
            drv_en          = 1'b1;
            drv_val         = bd[i];
        end
        @(negedge clk);
        bus_if.write = 1'b0;
        drv_en       = 1'b0;
    endtask

    // Checks tx every cycle of one frame, starting on the first start-bit cycle
    task automatic expect_frame(input logic [7:0] b, input int div);
        logic e;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < div; c++) begin
                if (k == 0)      e = 1'b0;
                else if (k == 9) e = 1'b1;
                else             e = b[k-1];
                chk($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, c), {31'd0, tx}, {31'd0, e});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_err           = 0;
        reset           = 1'b1;
        bus_if.bus_addr = '0;
        bus_if.read     = 1'b0;
        bus_if.write    = 1'b0;
        drv_en          = 1'b0;
        drv_val         = '0;
        done            = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        bus_read(A_STAT, v); chk("rst_status", {16'd0, v}, 32'h0002);
        bus_read(A_DIV, v);  chk("rst_div", {16'd0, v}, 32'd434);
        bus_read(A_TX, v);   chk("txdata_reads_0", {16'd0, v}, 32'd0);
        bus_read(A_RSVD, v); chk("rsvd_reads_0", {16'd0, v}, 32'd0);
        bus_read(20'h007FF, v); chk_undriven("miss_7ff", v);
        bus_read(20'h007FD, v); chk_undriven("miss_7fd", v);
        bus_read(20'h00804, v); chk_undriven("miss_804", v);
        bus_read(20'h00805, v); chk_undriven("miss_805", v);

        // Read and write in the same cycle: write wins, peripheral stays off the bus
        @(negedge clk);
        bus_if.bus_addr = A_DIV;
        bus_if.read     = 1'b1;
        bus_if.write    = 1'b1;
        drv_en          = 1'b1;
        drv_val         = 16'h0003;
        #1;
        chk("rw_bus_value", {16'd0, bus_data}, 32'h0003);
        @(negedge clk);
        bus_if.read  = 1'b0;
        bus_if.write = 1'b0;
        drv_en       = 1'b0;
        bus_read(A_DIV, v); chk("rw_div_written", {16'd0, v}, 32'd3);

        // Single byte 0xA5 at DIV=4, latency write edge N -> tx low at N+2
        bus_write(A_DIV, 16'd4);
        bus_write(A_TX, 16'h00A5);
        chk("lat_tx_n", {31'd0, tx}, 32'd1);
        chk("lat_irq_low", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("lat_tx_n1", {31'd0, tx}, 32'd1);
        @(negedge clk);
        expect_frame(8'hA5, 4);
        chk("a5_idle_tx", {31'd0, tx}, 32'd1);
        chk("a5_irq_back", {31'd0, irq}, 32'd1);

        // Three queued bytes at DIV=2: 60 cycles with no gaps between frames
        bus_write(A_DIV, 16'd2);
        ba[0] = A_TX; bd[0] = 16'h003C;
        ba[1] = A_TX; bd[1] = 16'h00C3;
        ba[2] = A_TX; bd[2] = 16'h005A;
        burst(3);
        expect_frame(8'h3C, 2);
        expect_frame(8'hC3, 2);
        expect_frame(8'h5A, 2);
        chk("b2b_idle_tx", {31'd0, tx}, 32'd1);
        chk("b2b_irq", {31'd0, irq}, 32'd1);

        // Nine back-to-back bytes fill the FIFO, tenth overflows
        bus_write(A_DIV, 16'd20);
        for (int i = 0; i < 8; i++) begin
            ba[i] = A_TX;
            bd[i] = 16'h0010 + 16'(i);
        end
        burst(8);
        bus_write(A_TX, 16'h0018);
        bus_read(A_STAT, v); chk("full_status", {16'd0, v}, 32'h0085);
        bus_write(A_TX, 16'h0099);
        bus_read(A_STAT, v); chk("ovf_status", {16'd0, v}, 32'h008D);
        bus_write(A_STAT, 16'h0000);
        bus_read(A_STAT, v); chk("ovf_kept", {16'd0, v}, 32'h008D);
        bus_write(A_STAT, 16'h0008);
        bus_read(A_STAT, v); chk("ovf_cleared", {16'd0, v}, 32'h0085);

        // Wait for the second frame to be popped, then drain and check order
        for (int i = 0; i < 400 && !done; i++) begin
            bus_read(A_STAT, v);
            if (v[7:4] == 4'd7) done = 1'b1;
            else @(negedge clk);
        end
        chk("drain_pop_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        for (int i = 1; i < 9; i++) begin
            expect_frame(8'h10 + 8'(i), 20);
        end
        bus_read(A_STAT, v); chk("drain_status", {16'd0, v}, 32'h0002);
        chk("drain_irq", {31'd0, irq}, 32'd1);

        // DIV change mid-frame applies to the following frame only
        bus_write(A_DIV, 16'd4);
        ba[0] = A_TX;  bd[0] = 16'h003A;
        ba[1] = A_TX;  bd[1] = 16'h00C5;
        ba[2] = A_DIV; bd[2] = 16'h0008;
        burst(3);
        expect_frame(8'h3A, 4);
        expect_frame(8'hC5, 8);
        chk("div_idle_tx", {31'd0, tx}, 32'd1);
        bus_read(A_DIV, v); chk("div_8", {16'd0, v}, 32'd8);
        bus_write(A_DIV, 16'd0);
        bus_read(A_DIV, v); chk("div_0_as_1", {16'd0, v}, 32'd1);

        // Reset in the middle of data bit 3 of a 0x00 frame
        bus_write(A_DIV, 16'd4);
        bus_write(A_TX, 16'h0000);
        repeat (19) @(negedge clk);
        chk("mid_bit3_low", {31'd0, tx}, 32'd0);
        bus_read(A_STAT, v); chk("mid_busy_status", {16'd0, v}, 32'h0006);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_tx", {31'd0, tx}, 32'd1);
        chk("rst2_irq", {31'd0, irq}, 32'd1);
        bus_read(A_STAT, v); chk("rst2_status", {16'd0, v}, 32'h0002);
        bus_read(A_DIV, v);  chk("rst2_div", {16'd0, v}, 32'd434);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst2_idle_%0d", i), {31'd0, tx}, 32'd1);
        end
        bus_write(A_DIV, 16'd4);
        bus_write(A_TX, 16'h0096);
        chk("post_rst_tx_n", {31'd0, tx}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        expect_frame(8'h96, 4);
        chk("post_rst_idle", {31'd0, tx}, 32'd1);
        chk("post_rst_irq", {31'd0, irq}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_uart_tx_periph
`default_nettype wire
